// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for the 5-stage MIPS pipeline.
// Inputs : clock, reset (sync, active-high); ID sources (id_rs, id_rt, id_uses_rt);
//          ID/EX load info (id_ex_mem_read, id_ex_rt); EX/MEM branch info
//          (ex_mem_branch, ex_mem_zero); data-memory handshake (mem_req, mem_ready).
// Outputs: PC / pipeline-register write enables, bubble selects and flushes
//          (combinational), plus registered ctrl_state, stall_count and the
//          sticky mem_timeout_err.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int COUNT_W     = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [4:0]         id_rs,
    input  logic [4:0]         id_rt,
    input  logic               id_uses_rt,
    input  logic               id_ex_mem_read,
    input  logic [4:0]         id_ex_rt,
    input  logic               ex_mem_branch,
    input  logic               ex_mem_zero,
    input  logic               mem_req,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               ctrl_hazard_if_id_write,
    output logic               ctrl_hazard_bubble,
    output logic               id_ex_write,
    output logic               ex_mem_write,
    output logic               mem_wb_bubble,
    output logic               flush_if_id,
    output logic               flush_id_ex,
    output logic               flush_ex_mem,
    output logic [1:0]         ctrl_state,
    output logic [COUNT_W-1:0] stall_count,
    output logic               mem_timeout_err
);
    localparam int WW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {RUN, LOAD_STALL, MEM_WAIT, ERROR} state_t;

    state_t        state, state_nx;
    logic [WW-1:0] wait_cnt, wait_nx;
    logic          err_set;
    logic          mem_stall, br_taken, load_use, freeze, stall_lu;

    assign mem_stall = mem_req & ~mem_ready;
    assign br_taken  = ex_mem_branch & ex_mem_zero;
    assign load_use  = id_ex_mem_read & (id_ex_rt != 5'd0) &
                       ((id_ex_rt == id_rs) | (id_uses_rt & (id_ex_rt == id_rt)));
    // Inside MEM_WAIT the access is already pending, so only mem_ready matters.
    assign freeze    = (state == ERROR) | ((state == MEM_WAIT) ? ~mem_ready : mem_stall);
    // A taken branch squashes the dependent instruction, so it wins over load-use;
    // the cycle after a load stall never stalls again for the same hazard.
    assign stall_lu  = ~freeze & ~br_taken & load_use & (state != LOAD_STALL);

    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= RUN;
            wait_cnt        <= '0;
            stall_count     <= '0;
            mem_timeout_err <= 1'b0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_nx;
            if (~pc_write && ~&stall_count)
                stall_count <= stall_count + COUNT_W'(1);
            if (err_set)
                mem_timeout_err <= 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        wait_nx  = wait_cnt;
        err_set  = 1'b0;
        if (state == ERROR) begin
            state_nx = ERROR;
        end else if (freeze) begin
            if (state != MEM_WAIT) begin
                state_nx = MEM_WAIT;
                wait_nx  = WW'(1);
            end else if (wait_cnt == WW'(MEM_TIMEOUT)) begin
                state_nx = ERROR;
                err_set  = 1'b1;
            end else begin
                wait_nx  = wait_cnt + WW'(1);
            end
        end else begin
            state_nx = stall_lu ? LOAD_STALL : RUN;
            wait_nx  = '0;
        end
    end

    always_comb begin
        pc_write                = ~reset & ~freeze & ~stall_lu;
        ctrl_hazard_if_id_write = ~reset & ~freeze & ~stall_lu;
        ctrl_hazard_bubble      = reset | stall_lu;
        id_ex_write             = reset | ~freeze;
        ex_mem_write            = reset | ~freeze;
        mem_wb_bubble           = reset | freeze;
        flush_if_id             = reset | (~freeze & br_taken);
        flush_id_ex             = reset | (~freeze & br_taken);
        flush_ex_mem            = reset | (~freeze & br_taken);
        ctrl_state              = state;
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed stimulus with a behavioural reference model and literal spot checks.
module tb_pipeline_hazard_ctrl;
    localparam int MT   = 4;
    localparam int CW   = 3;
    localparam int CMAX = (1 << CW) - 1;

    // Output vector order: pc, if_id_write, bubble, id_ex_write, ex_mem_write,
    // mem_wb_bubble, flush_if_id, flush_id_ex, flush_ex_mem
    localparam logic [8:0] NORMAL = 9'b110110000;
    localparam logic [8:0] FREEZE = 9'b000001000;
    localparam logic [8:0] BRANCH = 9'b110110111;
    localparam logic [8:0] LU     = 9'b001110000;
    localparam logic [8:0] RST    = 9'b001111111;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [4:0] id_rs = '0, id_rt = '0, id_ex_rt = '0;
    logic id_uses_rt = 0, id_ex_mem_read = 0, ex_mem_branch = 0, ex_mem_zero = 0;
    logic mem_req = 0, mem_ready = 0;
    logic pc_write, ctrl_hazard_if_id_write, ctrl_hazard_bubble, id_ex_write, ex_mem_write;
    logic mem_wb_bubble, flush_if_id, flush_id_ex, flush_ex_mem, mem_timeout_err;
    logic [1:0] ctrl_state;
    logic [CW-1:0] stall_count;

    int checks = 0, passed = 0;
    bit armed = 0;
    int ms = 0, nr = 0, cnt = 0, err = 0;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(MT), .COUNT_W(CW)) dut (
        .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt), .ex_mem_branch(ex_mem_branch),
        .ex_mem_zero(ex_mem_zero), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write(pc_write), .ctrl_hazard_if_id_write(ctrl_hazard_if_id_write),
        .ctrl_hazard_bubble(ctrl_hazard_bubble), .id_ex_write(id_ex_write),
        .ex_mem_write(ex_mem_write), .mem_wb_bubble(mem_wb_bubble), .flush_if_id(flush_if_id),
        .flush_id_ex(flush_id_ex), .flush_ex_mem(flush_ex_mem), .ctrl_state(ctrl_state),
        .stall_count(stall_count), .mem_timeout_err(mem_timeout_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_in();
        id_rs = 0; id_rt = 0; id_uses_rt = 0; id_ex_mem_read = 0; id_ex_rt = 0;
        ex_mem_branch = 0; ex_mem_zero = 0; mem_req = 0; mem_ready = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        tick();
        reset = 0;
    endtask

    // Reference model: checks every cycle at the falling edge, then advances.
    always @(negedge clock) begin
        logic br, lu, stalled;
        logic [8:0] exp, act;
        if (armed) begin
            br = ex_mem_branch && ex_mem_zero;
            lu = id_ex_mem_read && id_ex_rt != 0 &&
                 (id_ex_rt == id_rs || (id_uses_rt && id_ex_rt == id_rt));
            stalled = !reset && (ms == 3 || (ms == 2 ? !mem_ready : (mem_req && !mem_ready)));
            exp = reset ? RST : stalled ? FREEZE : br ? BRANCH : (lu && ms != 1) ? LU : NORMAL;
            act = {pc_write, ctrl_hazard_if_id_write, ctrl_hazard_bubble, id_ex_write,
                   ex_mem_write, mem_wb_bubble, flush_if_id, flush_id_ex, flush_ex_mem};
            chk("model_outputs", int'(act), int'(exp));
            chk("model_state", int'(ctrl_state), ms);
            chk("model_stall_count", int'(stall_count), cnt);
            chk("model_timeout_err", int'(mem_timeout_err), err);
            if (reset) begin
                ms = 0; nr = 0; cnt = 0; err = 0;
            end else begin
                if (!exp[8] && cnt < CMAX) cnt++;
                if (ms == 3) begin
                end else if (stalled) begin
                    nr++;
                    if (nr == MT + 1) begin ms = 3; err = 1; end
                    else ms = 2;
                end else begin
                    nr = 0;
                    ms = (!br && lu && ms != 1) ? 1 : 0;
                end
            end
        end
    end

    initial begin
        tick();
        armed = 1;
        tick();
        reset = 0;
        chk("reset_state", int'(ctrl_state), 0);
        chk("reset_count", int'(stall_count), 0);
        chk("reset_err", int'(mem_timeout_err), 0);

        // load-use on rs, then the single LOAD_STALL cycle
        id_ex_mem_read = 1; id_ex_rt = 2; id_rs = 2; #1;
        chk("lu_pc_write", int'(pc_write), 0);
        chk("lu_bubble", int'(ctrl_hazard_bubble), 1);
        tick();
        chk("ls_state", int'(ctrl_state), 1);
        chk("ls_pc_write", int'(pc_write), 1);
        clear_in();
        tick();
        chk("lu_count", int'(stall_count), 1);
        id_ex_mem_read = 1; id_ex_rt = 0; id_rs = 0; #1;
        chk("r0_no_stall", int'(pc_write), 1);
        tick();

        // rt sensitivity
        id_ex_mem_read = 1; id_ex_rt = 5; id_rt = 5; id_rs = 1; id_uses_rt = 1; #1;
        chk("rt_stall", int'(pc_write), 0);
        tick(); clear_in(); tick();
        id_ex_mem_read = 1; id_ex_rt = 5; id_rt = 5; id_rs = 1; id_uses_rt = 0; #1;
        chk("rt_unused", int'(pc_write), 1);
        tick(); clear_in();

        // branch overrides load-use
        id_ex_mem_read = 1; id_ex_rt = 3; id_rs = 3; ex_mem_branch = 1; ex_mem_zero = 1; #1;
        chk("br_flush", int'({flush_if_id, flush_id_ex, flush_ex_mem}), 7);
        chk("br_pc_write", int'(pc_write), 1);
        chk("br_no_bubble", int'(ctrl_hazard_bubble), 0);
        tick();
        chk("br_state", int'(ctrl_state), 0);
        ex_mem_zero = 0; #1;
        chk("nt_lu_stall", int'(pc_write), 0);
        tick(); clear_in(); tick();

        // memory wait, 3 not-ready cycles
        do_reset();
        mem_req = 1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("mw_bubble", int'(mem_wb_bubble), 1);
            tick();
        end
        mem_ready = 1; #1;
        chk("mw_ready_pc", int'(pc_write), 1);
        tick(); clear_in();
        chk("mw_state", int'(ctrl_state), 0);
        chk("mw_count", int'(stall_count), 3);
        // branch held through the wait: flushes only on the ready cycle
        mem_req = 1; ex_mem_branch = 1; ex_mem_zero = 1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("mwbr_noflush", int'(flush_if_id), 0);
            tick();
        end
        mem_ready = 1; #1;
        chk("mwbr_flush", int'(flush_ex_mem), 1);
        tick(); clear_in();

        // timeout
        do_reset();
        mem_req = 1;
        for (int i = 0; i < 5; i++) tick();
        chk("to_state", int'(ctrl_state), 3);
        chk("to_err", int'(mem_timeout_err), 1);
        mem_ready = 1; #1;
        chk("err_frozen_pc", int'(pc_write), 0);
        chk("err_frozen_mwb", int'(mem_wb_bubble), 1);
        for (int i = 0; i < 5; i++) tick();
        chk("count_sat", int'(stall_count), 7);

        // reset out of ERROR
        reset = 1; #1;
        chk("rst_pc_write", int'(pc_write), 0);
        chk("rst_flush", int'({flush_if_id, flush_id_ex, flush_ex_mem}), 7);
        tick(); reset = 0; clear_in();
        chk("rst_err_state", int'(ctrl_state), 0);
        chk("rst_err_count", int'(stall_count), 0);
        chk("rst_err_flag", int'(mem_timeout_err), 0);

        // reset in the middle of MEM_WAIT
        mem_req = 1;
        tick(); tick();
        chk("mid_wait_state", int'(ctrl_state), 2);
        reset = 1;
        tick(); reset = 0; clear_in();
        chk("rst_mw_state", int'(ctrl_state), 0);
        chk("rst_mw_count", int'(stall_count), 0);
        tick(); tick();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
